// File: rtl/psw_pkg.sv
// Shared definitions for the partitioned-subword saturating add/sub pipeline.
// Holds lane-mode encodings, a lane-width decoder and the signed saturation
// values for each lane width.
package psw_pkg;

  localparam logic [1:0] LANE4  = 2'b00;
  localparam logic [1:0] LANE8  = 2'b01;
  localparam logic [1:0] LANE16 = 2'b10;

  localparam logic [3:0]  SAT_POS4  = 4'h7;
  localparam logic [3:0]  SAT_NEG4  = 4'h8;
  localparam logic [7:0]  SAT_POS8  = 8'h7F;
  localparam logic [7:0]  SAT_NEG8  = 8'h80;
  localparam logic [15:0] SAT_POS16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG16 = 16'h8000;

  // Lane width in bits; the reserved code 11 behaves as 16-bit lanes.
  function automatic logic [4:0] lane_width(input logic [1:0] mode);
    case (mode)
      LANE4:   return 5'd4;
      LANE8:   return 5'd8;
      LANE16:  return 5'd16;
      default: return 5'd16;
    endcase
  endfunction

  // Saturation value for one lane, right-aligned in 16 bits.
  function automatic logic [15:0] sat_value(input logic [1:0] mode, input logic neg);
    case (mode)
      LANE4:   return {12'h000, (neg ? SAT_NEG4 : SAT_POS4)};
      LANE8:   return {8'h00, (neg ? SAT_NEG8 : SAT_POS8)};
      default: return neg ? SAT_NEG16 : SAT_POS16;
    endcase
  endfunction

endpackage

// File: rtl/psw_lane_unit.sv
// 4-bit add/sub slice of the partitioned-subword adder; purely combinational.
// Ports: a/b operand nibbles, sub, lane_start (nibble is lowest of its lane),
// cin_prev (carry from the nibble below); sum, cout, sign (of a), ovf.
module psw_lane_unit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       lane_start,
  input  logic       cin_prev,
  output logic [3:0] sum,
  output logic       cout,
  output logic       sign,
  output logic       ovf
);

  logic [3:0] beff;
  logic       cin;

  assign beff = sub ? ~b : b;
  // A lane boundary breaks the carry chain and injects the +1 of A + ~B + 1.
  assign cin  = lane_start ? sub : cin_prev;

  assign {cout, sum} = {1'b0, a} + {1'b0, beff} + {4'b0000, cin};

  assign sign = a[3];
  // Only meaningful when this nibble is the top of its lane.
  assign ovf  = (a[3] == beff[3]) && (sum[3] != a[3]);

endmodule

// File: rtl/psw_sat_addsub_pipe.sv
// Two-stage pipelined partitioned-subword add/sub with per-lane signed saturation.
// Latency: 2 edges from acceptance to OutValid; one beat per cycle when OutReady=1.
// Backpressure: holds up to 2 beats; InReady is combinational from OutReady.
// Ports: Clk/ResetN; InValid/InReady with A, B, LaneMode, Sub, SatEn per beat;
// OutValid/OutReady with Sum, LaneOvf (per nibble), Overflow; ClrSticky/StickyOvf.
module psw_sat_addsub_pipe
  import psw_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         LaneMode,
  input  logic               Sub,
  input  logic               SatEn,
  input  logic               ClrSticky,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   Sum,
  output logic [WIDTH/4-1:0] LaneOvf,
  output logic               Overflow,
  output logic               StickyOvf
);

  localparam int NIB = WIDTH / 4;

  logic             v1, v2;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] a1, b1;
  logic [1:0]       mode1;
  logic             sub1, sat1;

  assign s2_adv   = !v2 || OutReady;
  assign s1_adv   = !v1 || s2_adv;
  assign InReady  = s1_adv;
  assign OutValid = v2;

  // Stage 1: operand and control capture.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      mode1 <= LANE4;
      sub1  <= 1'b0;
      sat1  <= 1'b0;
    end else if (s1_adv) begin
      v1 <= InValid;
      if (InValid) begin
        a1    <= A;
        b1    <= B;
        mode1 <= LaneMode;
        sub1  <= Sub;
        sat1  <= SatEn;
      end
    end
  end

  // nmask = nibbles per lane minus one; nibble k sits at index (k & nmask)
  // inside its lane, whose top nibble is (k | nmask).
  logic [4:0] lw;
  logic [1:0] nmask;
  always_comb begin
    lw = lane_width(mode1);
    case (lw)
      5'd4:    nmask = 2'd0;
      5'd8:    nmask = 2'd1;
      default: nmask = 2'd3;
    endcase
  end

  logic [WIDTH-1:0] raw;
  logic [NIB-1:0]   co, sgn, ovf;
  logic             carry_unused;

  // The topmost nibble's carry-out has no consumer.
  assign carry_unused = co[NIB-1];

  for (genvar g = 0; g < NIB; g++) begin : g_lane
    logic cin_prev;
    if (g == 0) begin : g_first
      assign cin_prev = 1'b0;
    end else begin : g_rest
      assign cin_prev = co[g-1];
    end

    psw_lane_unit u_lane (
      .a          (a1[4*g +: 4]),
      .b          (b1[4*g +: 4]),
      .sub        (sub1),
      .lane_start ((2'(g) & nmask) == 2'b00),
      .cin_prev   (cin_prev),
      .sum        (raw[4*g +: 4]),
      .cout       (co[g]),
      .sign       (sgn[g]),
      .ovf        (ovf[g])
    );
  end

  // Per-nibble result select: every nibble looks up the overflow and sign of
  // its lane's top nibble and takes its slice of the lane saturation value.
  logic [WIDTH-1:0] sum_n;
  logic [NIB-1:0]   lovf_n;
  logic [15:0]      sv;
  int               top, pos;
  always_comb begin
    sum_n  = '0;
    lovf_n = '0;
    sv     = '0;
    top    = 0;
    pos    = 0;
    for (int k = 0; k < NIB; k++) begin
      top       = k | int'(nmask);
      pos       = k & int'(nmask);
      sv        = sat_value(mode1, sgn[top]);
      lovf_n[k] = ovf[top];
      sum_n[4*k +: 4] = (sat1 && ovf[top]) ? sv[4*pos +: 4] : raw[4*k +: 4];
    end
  end

  // Stage 2: result and flags; data only reloads with a valid beat so
  // outputs stay put while stalled.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      v2       <= 1'b0;
      Sum      <= '0;
      LaneOvf  <= '0;
      Overflow <= 1'b0;
    end else if (s2_adv) begin
      v2 <= v1;
      if (v1) begin
        Sum      <= sum_n;
        LaneOvf  <= lovf_n;
        Overflow <= |lovf_n;
      end
    end
  end

  // Set on an overflowing transfer takes priority over clear.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      StickyOvf <= 1'b0;
    end else if (v2 && OutReady && Overflow) begin
      StickyOvf <= 1'b1;
    end else if (ClrSticky) begin
      StickyOvf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psw_sat_addsub_pipe.sv
// Directed bench for psw_sat_addsub_pipe (WIDTH=16) with a result scoreboard.
// Expected values come from an integer per-lane arithmetic model.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_psw_sat_addsub_pipe;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        InValid, InReady;
  logic [15:0] A, B, Sum;
  logic [1:0]  LaneMode;
  logic        Sub, SatEn, ClrSticky;
  logic        OutValid, OutReady;
  logic [3:0]  LaneOvf;
  logic        Overflow, StickyOvf;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic [3:0]  lovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        held = 1'b0;
  logic [15:0] held_sum;
  logic [3:0]  held_lovf;

  always #5 Clk = ~Clk;

  psw_sat_addsub_pipe #(.WIDTH(16)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .InValid   (InValid),
    .InReady   (InReady),
    .A         (A),
    .B         (B),
    .LaneMode  (LaneMode),
    .Sub       (Sub),
    .SatEn     (SatEn),
    .ClrSticky (ClrSticky),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Sum       (Sum),
    .LaneOvf   (LaneOvf),
    .Overflow  (Overflow),
    .StickyOvf (StickyOvf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane-by-lane signed integer arithmetic, then range check.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] mode, input logic sub, input logic sat);
    exp_t e;
    int   l, m, mx, mn, av, bv, r;
    logic ov;
    e  = '0;
    l  = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 8 : 16;
    m  = (1 << l) - 1;
    mx = (1 << (l - 1)) - 1;
    mn = -(1 << (l - 1));
    for (int i = 0; i < 16 / l; i++) begin
      av = (int'(a) >> (i * l)) & m;
      bv = (int'(b) >> (i * l)) & m;
      if (av > mx) av = av - (1 << l);
      if (bv > mx) bv = bv - (1 << l);
      r  = sub ? (av - bv) : (av + bv);
      ov = (r > mx) || (r < mn);
      if (ov && sat) r = (r > mx) ? mx : mn;
      e.sum = e.sum | 16'((r & m) << (i * l));
      if (ov) begin
        for (int j = 0; j < l / 4; j++) e.lovf[i * (l / 4) + j] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Offers one beat and returns 1 unit after the edge that accepted it.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] mode, input logic sub, input logic sat);
    logic acc;
    acc      = 1'b0;
    A        = a;
    B        = b;
    LaneMode = mode;
    Sub      = sub;
    SatEn    = sat;
    InValid  = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk);
      #1;
    end
    chk("accept", 32'(acc), 32'd1);
    if (acc) sb.push_back(model(a, b, mode, sub, sat));
    InValid = 1'b0;
  endtask

  // Output monitor: scoreboard pop on transfer, hold check while stalled.
  always @(negedge Clk) begin
    if (!ResetN) begin
      held = 1'b0;
    end else begin
      if (OutValid && held) begin
        chk("hold_sum", 32'(Sum), 32'(held_sum));
        chk("hold_lovf", 32'(LaneOvf), 32'(held_lovf));
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          chk("out_unexpected", 32'(OutValid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_sum", 32'(Sum), 32'(mon_e.sum));
          chk("sb_lovf", 32'(LaneOvf), 32'(mon_e.lovf));
          chk("sb_ovf", 32'(Overflow), 32'(|mon_e.lovf));
        end
        held = 1'b0;
      end else if (OutValid) begin
        held      = 1'b1;
        held_sum  = Sum;
        held_lovf = LaneOvf;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    ResetN    = 1'b0;
    InValid   = 1'b0;
    A         = '0;
    B         = '0;
    LaneMode  = 2'b00;
    Sub       = 1'b0;
    SatEn     = 1'b1;
    ClrSticky = 1'b0;
    OutReady  = 1'b0;
    repeat (2) tick();

    // Reset state; InReady high even with OutReady low.
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_lovf", 32'(LaneOvf), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_sticky", 32'(StickyOvf), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd1);
    OutReady = 1'b1;
    ResetN   = 1'b1;

    // 4-bit add, no overflow; latency check.
    send(16'h0123, 16'h4501, 2'b00, 1'b0, 1'b1);
    chk("lat_after_accept", 32'(OutValid), 32'd0);
    tick();
    chk("lat_second_edge", 32'(OutValid), 32'd1);
    chk("t1_sum", 32'(Sum), 32'h4624);
    chk("t1_lovf", 32'(LaneOvf), 32'h0);
    tick();
    chk("t1_sticky", 32'(StickyOvf), 32'd0);

    // 4-bit mixed saturation.
    send(16'h6FED, 16'h52E5, 2'b00, 1'b0, 1'b1);
    tick();
    chk("t2_sum", 32'(Sum), 32'h71C2);
    chk("t2_lovf", 32'(LaneOvf), 32'h8);
    chk("t2_ovf", 32'(Overflow), 32'd1);
    tick();
    chk("t2_sticky", 32'(StickyOvf), 32'd1);

    // 8-bit sub, saturate then wrap on consecutive beats.
    send(16'h807F, 16'h01FF, 2'b01, 1'b1, 1'b1);
    send(16'h807F, 16'h01FF, 2'b01, 1'b1, 1'b0);
    chk("t3_sat_sum", 32'(Sum), 32'h807F);
    chk("t3_sat_lovf", 32'(LaneOvf), 32'hF);
    tick();
    chk("t3_wrap_sum", 32'(Sum), 32'h7F80);
    chk("t3_wrap_lovf", 32'(LaneOvf), 32'hF);
    tick();

    // 16-bit add, then sticky clear behaviour.
    send(16'h7FFF, 16'h0001, 2'b10, 1'b0, 1'b1);
    tick();
    chk("t4_sum", 32'(Sum), 32'h7FFF);
    chk("t4_ovf", 32'(Overflow), 32'd1);
    tick();
    ClrSticky = 1'b1;
    tick();
    ClrSticky = 1'b0;
    chk("clr_sticky", 32'(StickyOvf), 32'd0);
    send(16'h7FFF, 16'h0001, 2'b10, 1'b0, 1'b1);
    tick();
    ClrSticky = 1'b1;
    tick();
    ClrSticky = 1'b0;
    chk("set_wins", 32'(StickyOvf), 32'd1);

    // Reserved mode behaves as 16-bit; wrap.
    send(16'h7FFF, 16'h0001, 2'b11, 1'b0, 1'b0);
    tick();
    chk("mode11_sum", 32'(Sum), 32'h8000);
    tick();

    // Backpressure: two beats held, third waits.
    OutReady = 1'b0;
    send(16'h1111, 16'h2222, 2'b00, 1'b0, 1'b1);
    send(16'h7000, 16'h7000, 2'b01, 1'b0, 1'b1);
    A        = 16'h0F0F;
    B        = 16'h0101;
    LaneMode = 2'b01;
    Sub      = 1'b1;
    SatEn    = 1'b1;
    InValid  = 1'b1;
    @(negedge Clk);
    chk("bp_inready_c3", 32'(InReady), 32'd0);
    tick();
    @(negedge Clk);
    chk("bp_inready_c4", 32'(InReady), 32'd0);
    chk("bp_outvalid", 32'(OutValid), 32'd1);
    tick();
    OutReady = 1'b1;
    @(negedge Clk);
    chk("bp_inready_release", 32'(InReady), 32'd1);
    tick();
    sb.push_back(model(A, B, LaneMode, Sub, SatEn));
    InValid = 1'b0;
    chk("bp_stream1", 32'(OutValid), 32'd1);
    tick();
    chk("bp_stream2", 32'(OutValid), 32'd1);
    tick();
    chk("bp_drained", 32'(OutValid), 32'd0);

    // Reset mid-operation with both stages full.
    OutReady = 1'b0;
    send(16'h7777, 16'h1111, 2'b00, 1'b0, 1'b1);
    send(16'h1234, 16'h1111, 2'b10, 1'b0, 1'b1);
    chk("mid_full", 32'(OutValid), 32'd1);
    #2;
    ResetN = 1'b0;
    #1;
    chk("mid_outvalid", 32'(OutValid), 32'd0);
    chk("mid_sum", 32'(Sum), 32'd0);
    chk("mid_lovf", 32'(LaneOvf), 32'd0);
    chk("mid_ovf", 32'(Overflow), 32'd0);
    chk("mid_sticky", 32'(StickyOvf), 32'd0);
    chk("mid_inready", 32'(InReady), 32'd1);
    sb.delete();
    OutReady = 1'b1;
    tick();
    ResetN = 1'b1;
    send(16'h0102, 16'h0304, 2'b01, 1'b0, 1'b1);
    chk("post_rst_lat1", 32'(OutValid), 32'd0);
    tick();
    chk("post_rst_lat2", 32'(OutValid), 32'd1);
    chk("post_rst_sum", 32'(Sum), 32'h0406);
    tick();

    // Random back-to-back beats across all modes.
    for (int n = 0; n < 24; n++) begin
      send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
